// File: rtl/dist_mean_detector_if.sv
// ---------------------------------------------------------------------------
// dist_mean_detector_if
//   Bundles the control, sample stream and result signals of the distance-mean
//   lock detector.
//   master : drives start/auto/abort, the distance stream and the threshold;
//            observes enable/busy/mean/lock.
//   slave  : the detector itself.
//   Signals:
//     start_i, auto_i, abort_i   window control
//     dist_val_i, dist_i         distance sample stream
//     threshold_i                lock threshold
//     enable_o                   calculator enable (high while accumulating)
//     busy_o                     window in progress
//     mean_o, mean_val_o         rounded mean and its one-cycle update strobe
//     lock_o                     mean below threshold
// ---------------------------------------------------------------------------
interface dist_mean_detector_if #(
    parameter int DIST_WIDTH = 16
);
    logic                  start_i;
    logic                  auto_i;
    logic                  abort_i;
    logic                  dist_val_i;
    logic [DIST_WIDTH-1:0] dist_i;
    logic [DIST_WIDTH-1:0] threshold_i;
    logic                  enable_o;
    logic                  busy_o;
    logic [DIST_WIDTH-1:0] mean_o;
    logic                  mean_val_o;
    logic                  lock_o;

    modport master (
        output start_i, auto_i, abort_i, dist_val_i, dist_i, threshold_i,
        input  enable_o, busy_o, mean_o, mean_val_o, lock_o
    );

    modport slave (
        input  start_i, auto_i, abort_i, dist_val_i, dist_i, threshold_i,
        output enable_o, busy_o, mean_o, mean_val_o, lock_o
    );
endinterface

// File: rtl/dist_mean_detector.sv
// ---------------------------------------------------------------------------
// dist_mean_detector
//   Averages the error-distance stream over a 2^LOG2_WIN-sample window, rounds
//   the mean, and declares lock when the mean is strictly below the threshold.
//   Holds the distance calculator enabled for the duration of each window.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    dist_mean_detector_if.slave (control, samples, results)
// ---------------------------------------------------------------------------
module dist_mean_detector #(
    parameter int DIST_WIDTH = 16,
    parameter int LOG2_WIN   = 10
) (
    input logic                  clk,
    input logic                  reset,
    dist_mean_detector_if.slave  bus
);
    // One extra bit over the full-window sum so the rounding add cannot wrap.
    localparam int ACC_WIDTH = DIST_WIDTH + LOG2_WIN + 1;

    localparam logic [LOG2_WIN-1:0]  CNT_LAST = '1;
    localparam logic [ACC_WIDTH-1:0] ROUND    = ACC_WIDTH'(1) << (LOG2_WIN - 1);
    localparam logic [ACC_WIDTH-1:0] MEAN_MAX = ACC_WIDTH'({DIST_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [ACC_WIDTH-1:0]  acc;
    logic [LOG2_WIN-1:0]   cnt;

    logic                  take_sample;
    logic                  clear_acc;
    logic                  result_fire;
    logic [ACC_WIDTH-1:0]  acc_rounded;
    logic [ACC_WIDTH-1:0]  acc_shifted;
    logic [DIST_WIDTH-1:0] mean_next;

    // NOTE: every signal driven from always_comb gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        take_sample = 1'b0;
        result_fire = 1'b0;

        unique case (state)
            IDLE: begin
                // abort_i in IDLE suppresses a simultaneous start.
                if (bus.start_i && !bus.abort_i) state_next = ACCUM;
            end
            ACCUM: begin
                if (bus.abort_i) begin
                    state_next = IDLE;
                end else if (bus.dist_val_i) begin
                    take_sample = 1'b1;
                    if (cnt == CNT_LAST) state_next = RESULT;
                end
            end
            RESULT: begin
                if (bus.abort_i) begin
                    state_next = IDLE;
                end else begin
                    result_fire = 1'b1;
                    state_next  = bus.auto_i ? ACCUM : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulator only holds a live sum while in ACCUM; every other state
    // (and an abort) leaves it zeroed, ready for the next window.
    assign clear_acc = (state != ACCUM) || bus.abort_i;

    // Round half up, then saturate to the output width.
    assign acc_rounded = acc + ROUND;
    assign acc_shifted = acc_rounded >> LOG2_WIN;
    assign mean_next   = (acc_shifted > MEAN_MAX) ? {DIST_WIDTH{1'b1}}
                                                  : acc_shifted[DIST_WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= '0;
            cnt            <= '0;
            bus.mean_o     <= '0;
            bus.lock_o     <= 1'b0;
            bus.mean_val_o <= 1'b0;
        end else begin
            bus.mean_val_o <= 1'b0;

            if (clear_acc) begin
                acc <= '0;
                cnt <= '0;
            end else if (take_sample) begin
                acc <= acc + ACC_WIDTH'(bus.dist_i);
                cnt <= cnt + LOG2_WIN'(1);
            end

            if (result_fire) begin
                bus.mean_o     <= mean_next;
                bus.lock_o     <= (mean_next < bus.threshold_i);
                bus.mean_val_o <= 1'b1;
            end
        end
    end

    // Pure decodes of the state register.
    assign bus.enable_o = (state == ACCUM);
    assign bus.busy_o   = (state != IDLE);

endmodule

// File: tb/tb_dist_mean_detector.sv
// ---------------------------------------------------------------------------
// tb_dist_mean_detector
//   Self-checking bench for dist_mean_detector with a 4-sample window.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dist_mean_detector;
    localparam int DW      = 16;
    localparam int LW      = 2;
    localparam int WIN     = 1 << LW;
    localparam int CLK_P   = 10;
    localparam logic [DW-1:0] JUNK = 16'h1234;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #(CLK_P/2) clk = ~clk;

    dist_mean_detector_if #(.DIST_WIDTH(DW)) bus ();

    dist_mean_detector #(.DIST_WIDTH(DW), .LOG2_WIN(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0][DW-1:0] smp;
        logic [DW-1:0]      thr;
        logic [DW-1:0]      mean;
        logic               lock;
    } vec_t;

    vec_t vecs[8];

    // One non-auto window: start, four samples (optionally with gaps and
    // ignored junk valids in IDLE/RESULT), then check timing and result.
    task automatic run_window(input logic [3:0][DW-1:0] smp, input logic [DW-1:0] thr,
                              input logic [DW-1:0] exp_mean, input logic exp_lock,
                              input bit noisy, input string tag);
        int g;
        if (noisy) begin
            repeat (3) begin
                @(negedge clk);
                bus.dist_val_i = 1'b1;
                bus.dist_i     = JUNK;
            end
        end
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.threshold_i = thr;
        bus.dist_val_i  = noisy;
        bus.dist_i      = JUNK;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            check($sformatf("%s enable in accum %0d", tag, i), bus.enable_o, 1'b1);
            if (noisy) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    bus.dist_val_i = 1'b0;
                    bus.dist_i     = JUNK;
                    @(negedge clk);
                    check($sformatf("%s enable in gap", tag), bus.enable_o, 1'b1);
                end
            end
            bus.dist_val_i = 1'b1;
            bus.dist_i     = smp[i];
        end
        // Cycle after the last accepted sample: RESULT.
        @(negedge clk);
        check($sformatf("%s enable low in result", tag), bus.enable_o, 1'b0);
        check($sformatf("%s busy in result", tag), bus.busy_o, 1'b1);
        check($sformatf("%s no early pulse", tag), bus.mean_val_o, 1'b0);
        bus.dist_val_i = noisy;
        bus.dist_i     = JUNK;
        // Two clocks after the last valid sample: result strobe.
        @(negedge clk);
        bus.dist_val_i = 1'b0;
        check($sformatf("%s mean_val pulse", tag), bus.mean_val_o, 1'b1);
        check($sformatf("%s mean", tag), bus.mean_o, exp_mean);
        check($sformatf("%s lock", tag), bus.lock_o, exp_lock);
        check($sformatf("%s busy after", tag), bus.busy_o, 1'b0);
        @(negedge clk);
        check($sformatf("%s pulse one cycle", tag), bus.mean_val_o, 1'b0);
    endtask

    task automatic feed_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i    = 1'b0;
        bus.dist_val_i = 1'b1;
        bus.dist_i     = a;
        @(negedge clk);
        bus.dist_i     = b;
        @(negedge clk);
        bus.dist_val_i = 1'b0;
    endtask

    // Watchdog: the bench is fully cycle-scheduled, so this only fires on a
    // bench bug or a hung simulator.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] av[3];
        time           pulse_t[3];
        int            pulses;
        int            en_low;

        vecs[0] = '{smp: {16'd41, 16'd30, 16'd20, 16'd10}, thr: 16'd30,   mean: 16'd25,   lock: 1'b1};
        vecs[1] = '{smp: {16'd0, 16'd1, 16'd1, 16'd1},     thr: 16'd5,    mean: 16'd1,    lock: 1'b1};
        vecs[2] = '{smp: {16'd0, 16'd2, 16'd2, 16'd2},     thr: 16'd2,    mean: 16'd2,    lock: 1'b0};
        vecs[3] = '{smp: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, thr: 16'hFFFF, mean: 16'hFFFF, lock: 1'b0};
        vecs[4] = '{smp: {16'd8, 16'd8, 16'd8, 16'd8},     thr: 16'd8,    mean: 16'd8,    lock: 1'b0};
        vecs[5] = '{smp: {16'd8, 16'd8, 16'd8, 16'd8},     thr: 16'd9,    mean: 16'd8,    lock: 1'b1};
        vecs[6] = '{smp: {16'd1, 16'd0, 16'd0, 16'd0},     thr: 16'd1,    mean: 16'd0,    lock: 1'b1};
        vecs[7] = '{smp: {16'd4, 16'd3, 16'd2, 16'd1},     thr: 16'd3,    mean: 16'd3,    lock: 1'b0};

        bus.start_i     = 1'b0;
        bus.auto_i      = 1'b0;
        bus.abort_i     = 1'b0;
        bus.dist_val_i  = 1'b0;
        bus.dist_i      = '0;
        bus.threshold_i = '0;

        repeat (3) @(negedge clk);
        check("reset enable", bus.enable_o, 1'b0);
        check("reset busy", bus.busy_o, 1'b0);
        check("reset mean", bus.mean_o, 16'd0);
        check("reset mean_val", bus.mean_val_o, 1'b0);
        check("reset lock", bus.lock_o, 1'b0);
        reset = 1'b0;

        // Table of single windows.
        for (int v = 0; v < 8; v++)
            run_window(vecs[v].smp, vecs[v].thr, vecs[v].mean, vecs[v].lock, 1'b0,
                       $sformatf("vec%0d", v));

        // Gaps in valid plus valids in IDLE and RESULT: same mean as vec0.
        run_window(vecs[0].smp, vecs[0].thr, 16'd25, 1'b1, 1'b1, "gaps");

        // Auto mode, three back-to-back windows at full rate.
        av[0] = 16'd100; av[1] = 16'd200; av[2] = 16'd300;
        pulses = 0;
        en_low = 0;
        @(negedge clk);
        bus.auto_i      = 1'b1;
        bus.start_i     = 1'b1;
        bus.threshold_i = 16'd250;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i <= WIN; i++) begin
                @(negedge clk);
                bus.start_i = 1'b0;
                if (!bus.enable_o) en_low++;
                if (bus.mean_val_o) begin
                    if (pulses < 3) begin
                        pulse_t[pulses] = $time;
                        check($sformatf("auto mean %0d", pulses), bus.mean_o, av[pulses]);
                        check($sformatf("auto lock %0d", pulses), bus.lock_o,
                              (pulses < 2) ? 1'b1 : 1'b0);
                    end
                    pulses++;
                end
                bus.dist_val_i = 1'b1;
                // The WIN-th slot is the RESULT cycle: its valid must be dropped.
                bus.dist_i     = (i == WIN) ? 16'hBEEF : av[w];
                if (w == 2 && i == WIN - 1) bus.auto_i = 1'b0;
            end
        end
        @(negedge clk);
        bus.dist_val_i = 1'b0;
        if (bus.mean_val_o) begin
            if (pulses < 3) begin
                pulse_t[pulses] = $time;
                check("auto mean 2", bus.mean_o, av[2]);
                check("auto lock 2", bus.lock_o, 1'b0);
            end
            pulses++;
        end
        check("auto pulse count", pulses, 3);
        check("auto enable low cycles", en_low, 3);
        if (pulses == 3) begin
            // Period = four full-rate samples plus the single RESULT cycle.
            check("auto spacing 0-1", 32'(pulse_t[1] - pulse_t[0]), (WIN + 1) * CLK_P);
            check("auto spacing 1-2", 32'(pulse_t[2] - pulse_t[1]), (WIN + 1) * CLK_P);
        end
        check("auto stops", bus.busy_o, 1'b0);

        // Establish a known held result, then abort mid-window.
        run_window(vecs[0].smp, vecs[0].thr, 16'd25, 1'b1, 1'b0, "pre-abort");
        feed_two(16'd900, 16'd900);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("abort busy", bus.busy_o, 1'b0);
        check("abort enable", bus.enable_o, 1'b0);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mean_val_o) pulses++;
        end
        check("abort no pulse", pulses, 0);
        check("abort mean held", bus.mean_o, 16'd25);
        check("abort lock held", bus.lock_o, 1'b1);

        // Abort during RESULT suppresses the update.
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.threshold_i = 16'd1000;
        for (int i = 0; i < WIN; i++) begin
            @(negedge clk);
            bus.start_i    = 1'b0;
            bus.dist_val_i = 1'b1;
            bus.dist_i     = 16'd500;
        end
        @(negedge clk);
        bus.dist_val_i = 1'b0;
        bus.abort_i    = 1'b1;
        check("abort-result in result", bus.busy_o, 1'b1);
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("abort-result no pulse", bus.mean_val_o, 1'b0);
        check("abort-result mean held", bus.mean_o, 16'd25);
        check("abort-result idle", bus.busy_o, 1'b0);

        // abort_i with start_i in IDLE: start ignored.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        check("idle abort blocks start", bus.busy_o, 1'b0);

        // Reset mid-window clears everything; a fresh window still works.
        feed_two(16'd700, 16'd700);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", bus.busy_o, 1'b0);
        check("midreset enable", bus.enable_o, 1'b0);
        check("midreset mean", bus.mean_o, 16'd0);
        check("midreset lock", bus.lock_o, 1'b0);
        check("midreset mean_val", bus.mean_val_o, 1'b0);
        run_window(vecs[0].smp, vecs[0].thr, 16'd25, 1'b1, 1'b0, "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
